reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset sequencer for the system clock domain. It sits directly downstream of the iCE40 PLL wrapper. It is clocked by the PLL output clock and consumes the PLL `locked` flag. It holds the design in reset until lock has been continuously stable for a programmable time, then releases a staged pair of resets: peripherals first, then core. It reasserts both resets on any loss of lock and counts those losses for debug.

## Interface

Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before any release. Must be ≥ 1.
- `STAGE_GAP_CYCLES`, default 16: cycles between the `periph_reset` release and the `core_reset` release. Must be ≥ 1.
- `SYNC_STAGES`, default 2: flip-flop depth of the `locked` synchronizer. Must be ≥ 2.

Ports:
- `clock`, input, 1: PLL output clock (24 MHz). Single clock domain.
- `reset`, input, 1: synchronous, active-high. Already synchronized to `clock` by its source.
- `locked`, input, 1: raw PLL lock flag, asynchronous to `clock`.
- `periph_reset`, output, 1: active-high reset for the peripheral domain. Registered.
- `core_reset`, output, 1: active-high reset for the core. Registered.
- `running`, output, 1: high only when both resets are released. Registered.
- `lock_drops`, output, 8: count of lock losses after a release began. Saturates at 255.

## Operation

- `locked` passes through a `SYNC_STAGES`-deep flop chain; the chain output is `locked_s`. Only `locked_s` is used internally.
- One counter is shared between STABILIZE and GAP. Its width is clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES)) + 1.
- States and output values:
  - WAIT_LOCK: `periph_reset`=1, `core_reset`=1, `running`=0. The counter is held at 0. If `locked_s`=1, go to STABILIZE.
  - STABILIZE: outputs as in WAIT_LOCK. The counter increments while `locked_s`=1. If `locked_s`=0, go to WAIT_LOCK and clear the counter, so a lock glitch restarts the count. When the counter equals LOCK_STABLE_CYCLES−1 and `locked_s`=1, go to GAP, clear the counter, and drive `periph_reset` to 0.
  - GAP: `periph_reset`=0, `core_reset`=1, `running`=0. The counter increments each cycle. When the counter equals STAGE_GAP_CYCLES−1, go to RUN and drive `core_reset` to 0 and `running` to 1.
  - RUN: `periph_reset`=0, `core_reset`=0, `running`=1. The state holds while `locked_s`=1.
- Lock loss in GAP or RUN (`locked_s`=0):
  - Go to WAIT_LOCK.
  - Both resets return to 1 and `running` returns to 0 on the same edge.
  - `lock_drops` increments by 1, unless it is already 255.
- Lock loss in STABILIZE does not increment `lock_drops`.
- Outputs are registered and change on the same edge as the state transition. There is no combinational path from `locked` to any output.
- `reset` input:
  - Forces WAIT_LOCK, counter=0, all synchronizer flops=0, `periph_reset`=1, `core_reset`=1, `running`=0, `lock_drops`=0.
  - `reset` has priority over every other event, including a simultaneous lock loss.
  - Asserting `reset` mid-sequence (in STABILIZE, GAP or RUN) behaves identically.
- Reset values of all outputs: `periph_reset`=1, `core_reset`=1, `running`=0, `lock_drops`=0.
- `periph_reset` and `core_reset` are never 0 while the other has the wrong order: `core_reset`=0 implies `periph_reset`=0.

## Timing

- Edge 0 is the first edge where `locked` is sampled high, with `locked` held high and `reset` low from then on.
  - `locked_s` goes high after edge SYNC_STAGES−1.
  - The state enters STABILIZE at edge SYNC_STAGES.
  - `periph_reset` falls at edge SYNC_STAGES+LOCK_STABLE_CYCLES. With defaults this is edge 1026.
  - `core_reset` falls and `running` rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES+STAGE_GAP_CYCLES. With defaults this is edge 1042.
- Lock-loss latency: `locked` is sampled low at edge m. Both resets reassert, `running` falls and `lock_drops` updates at edge m+SYNC_STAGES.
- Glitch rule: a low on `locked_s` lasting 1 cycle anywhere in STABILIZE restarts the full LOCK_STABLE_CYCLES count from the next high.
- After `reset` deasserts, the earliest release follows the Edge 0 rule, counted from the first post-reset sample of `locked` high.

## Test plan

The bench uses LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, SYNC_STAGES=2.

- Clean lock:
  - Stimulus: `locked` is held high from edge 0.
  - Required response: `periph_reset` falls at edge 10. `core_reset` falls and `running` rises at edge 14. `lock_drops`=0.
- Glitch during STABILIZE:
  - Stimulus: `locked` is high from edge 0, low for 1 cycle sampled at edge 5, then high again.
  - Required response: no release before edge 16. `periph_reset` falls at edge 16. `core_reset` falls at edge 20. `lock_drops`=0.
- Loss in RUN:
  - Stimulus: after `running`=1, `locked` is sampled low at edge m.
  - Required response: both resets =1, `running`=0 and `lock_drops`=1 at edge m+2. On relock, the full sequence repeats.
- Loss in GAP:
  - Stimulus: `locked` is sampled low at edge 11.
  - Required response: `periph_reset` returns to 1 at edge 13. `core_reset` never falls. `lock_drops`=1.
- Saturation:
  - Stimulus: 260 lock-loss/relock cycles, each reaching RUN.
  - Required response: `lock_drops` reads 255 and does not wrap.
- Reset mid-operation and priority:
  - Stimulus: in RUN with `lock_drops`=3, assert `reset` for 1 cycle on the same edge that `locked_s` falls.
  - Required response: all outputs return to their reset values and `lock_drops`=0, not 4. The release timing restarts from the post-reset lock sample.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release for the PLL clock domain: waits for a stable synchronized lock,
// releases peripherals, then core after a gap, and falls back to full reset on lock loss.
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       running,
    output logic [7:0] lock_drops,
    output logic [1:0] state_dbg
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        GAP       = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       drops_q, drops_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             locked_s;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             running_q, running_d;

    // The raw lock flag is asynchronous; only the chain output is trusted.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            drops_q   <= '0;
            periph_q  <= 1'b1;
            core_q    <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drops_q   <= drops_d;
            periph_q  <= periph_d;
            core_q    <= core_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drops_d = drops_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the transition edge.
    always_comb begin
        periph_d  = (state_d == WAIT_LOCK) || (state_d == STABILIZE);
        core_d    = (state_d != RUN);
        running_d = (state_d == RUN);
    end

    assign periph_reset = periph_q;
    assign core_reset   = core_q;
    assign running      = running_q;
    assign lock_drops   = drops_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random lock/reset traffic,
// checked every cycle against a run-length model of the release rules.
module tb_reset_sequencer;

    localparam int LSC = 8;
    localparam int GAPC = 4;
    localparam int SS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       periph_reset, core_reset, running;
    logic [7:0] lock_drops;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Model: lock as seen after the synchronizer delay, and the length of its current high run.
    logic       lhist[$];
    int         run_len;
    logic [7:0] m_drops;
    logic       exp_periph, exp_core, exp_running;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_GAP_CYCLES(GAPC),
        .SYNC_STAGES(SS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .locked(locked),
        .periph_reset(periph_reset),
        .core_reset(core_reset),
        .running(running),
        .lock_drops(lock_drops),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge(input logic l, input logic r);
        logic seen;
        if (r) begin
            lhist.delete();
            for (int i = 0; i < SS; i++) lhist.push_back(1'b0);
            run_len = 0;
            m_drops = 8'd0;
        end else begin
            seen = lhist.pop_front();
            lhist.push_back(l);
            if (seen) begin
                if (run_len < 100000) run_len++;
            end else begin
                if (run_len >= LSC + 1 && m_drops != 8'hFF) m_drops++;
                run_len = 0;
            end
        end
        exp_periph  = (run_len < LSC + 1);
        exp_core    = (run_len < LSC + GAPC + 1);
        exp_running = !exp_core;
    endtask

    task automatic tick(input logic l, input logic r);
        locked = l;
        reset  = r;
        @(posedge clock);
        model_edge(l, r);
        #1;
        chk("periph_reset", {7'd0, periph_reset}, {7'd0, exp_periph});
        chk("core_reset", {7'd0, core_reset}, {7'd0, exp_core});
        chk("running", {7'd0, running}, {7'd0, exp_running});
        chk("lock_drops", lock_drops, m_drops);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < SS; i++) lhist.push_back(1'b0);
        run_len = 0;
        m_drops = 8'd0;

        // Reset values
        do_reset();
        chk("rst_periph", {7'd0, periph_reset}, 8'd1);
        chk("rst_core", {7'd0, core_reset}, 8'd1);
        chk("rst_running", {7'd0, running}, 8'd0);
        chk("rst_drops", lock_drops, 8'd0);

        // Clean lock: periph at edge 10, core/running at edge 14
        for (int e = 0; e < 20; e++) begin
            tick(1'b1, 1'b0);
            if (e == 9)  chk("clean_periph_e9", {7'd0, periph_reset}, 8'd1);
            if (e == 10) chk("clean_periph_e10", {7'd0, periph_reset}, 8'd0);
            if (e == 13) chk("clean_core_e13", {7'd0, core_reset}, 8'd1);
            if (e == 14) chk("clean_core_e14", {7'd0, core_reset}, 8'd0);
            if (e == 14) chk("clean_running_e14", {7'd0, running}, 8'd1);
        end
        chk("clean_drops", lock_drops, 8'd0);

        // Loss in RUN: sampled low at m, visible at m+2, then full relock
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("runloss_m1_running", {7'd0, running}, 8'd1);
        tick(1'b1, 1'b0);
        chk("runloss_m2_running", {7'd0, running}, 8'd0);
        chk("runloss_m2_periph", {7'd0, periph_reset}, 8'd1);
        chk("runloss_m2_core", {7'd0, core_reset}, 8'd1);
        chk("runloss_m2_drops", lock_drops, 8'd1);
        for (int e = 0; e < 20; e++) tick(1'b1, 1'b0);
        chk("relock_running", {7'd0, running}, 8'd1);

        // Glitch during STABILIZE: single low sampled at edge 5
        do_reset();
        for (int e = 0; e < 24; e++) begin
            tick((e == 5) ? 1'b0 : 1'b1, 1'b0);
            if (e < 16) chk("glitch_no_early_release", {7'd0, periph_reset}, 8'd1);
            if (e == 16) chk("glitch_periph_e16", {7'd0, periph_reset}, 8'd0);
            if (e == 19) chk("glitch_core_e19", {7'd0, core_reset}, 8'd1);
            if (e == 20) chk("glitch_core_e20", {7'd0, core_reset}, 8'd0);
        end
        chk("glitch_drops", lock_drops, 8'd0);

        // Loss in GAP: low sampled at edge 11 and held low
        do_reset();
        for (int e = 0; e < 18; e++) begin
            tick((e < 11) ? 1'b1 : 1'b0, 1'b0);
            chk("gaploss_core_never_falls", {7'd0, core_reset}, 8'd1);
            if (e == 12) chk("gaploss_periph_e12", {7'd0, periph_reset}, 8'd0);
            if (e == 13) chk("gaploss_periph_e13", {7'd0, periph_reset}, 8'd1);
        end
        chk("gaploss_drops", lock_drops, 8'd1);

        // Reset priority over a simultaneous lock loss, with three drops recorded
        do_reset();
        for (int e = 0; e < 16; e++) tick(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < 3; e++) tick(1'b0, 1'b0);
            for (int e = 0; e < 16; e++) tick(1'b1, 1'b0);
        end
        chk("prio_pre_drops", lock_drops, 8'd3);
        chk("prio_pre_running", {7'd0, running}, 8'd1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("prio_drops", lock_drops, 8'd0);
        chk("prio_periph", {7'd0, periph_reset}, 8'd1);
        chk("prio_running", {7'd0, running}, 8'd0);
        for (int e = 0; e < 16; e++) begin
            tick(1'b1, 1'b0);
            if (e == 9)  chk("prio_periph_e9", {7'd0, periph_reset}, 8'd1);
            if (e == 10) chk("prio_periph_e10", {7'd0, periph_reset}, 8'd0);
            if (e == 14) chk("prio_running_e14", {7'd0, running}, 8'd1);
        end

        // Saturation: 260 loss/relock cycles, each reaching RUN
        do_reset();
        for (int k = 0; k < 260; k++) begin
            for (int e = 0; e < 15; e++) tick(1'b1, 1'b0);
            for (int e = 0; e < 3; e++) tick(1'b0, 1'b0);
            if (k == 253) chk("sat_254", lock_drops, 8'd254);
        end
        chk("sat_255", lock_drops, 8'd255);

        // Random lock/reset traffic
        do_reset();
        for (int k = 0; k < 60; k++) begin
            int hi_len, lo_len;
            hi_len = $urandom_range(1, 20);
            lo_len = $urandom_range(1, 4);
            for (int e = 0; e < hi_len; e++) tick(1'b1, ($urandom_range(0, 40) == 0));
            for (int e = 0; e < lo_len; e++) tick(1'b0, ($urandom_range(0, 20) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
